// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the RV32I pipeline and producer of
// the IF/ID pipeline register consumed by decode.
//
// The stage holds the PC and issues one word read at a time to instruction
// memory. A read stays asserted with a stable address until imem_resp.
// Returned words go into a two-deep queue: the IF/ID entry ("out") plus a
// one-entry skid buffer ("buf") that absorbs decode backpressure. An EX-stage
// redirect flushes both slots. If a read is still in flight, its eventual
// response is discarded.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_addr         word-aligned fetch address
//   imem_rmask        4'hF while a read is requested, 4'h0 when idle
//   imem_rdata        instruction word, valid with imem_resp
//   imem_resp         one-cycle response strobe for the outstanding read
//   stall             decode cannot accept the IF/ID entry this cycle
//   redirect_valid    one-cycle flush-and-redirect from EX
//   redirect_pc       redirect target (word aligned)
//   out_valid         IF/ID entry valid
//   out_pc            PC of the entry
//   out_pcplus4       out_pc + 4 (wraps at 2^32)
//   out_instruction   fetched instruction word
//   out_pc_wdata      sequential next PC of the entry (= out_pcplus4)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc_wdata
);

    typedef enum logic [1:0] {
        REQ,
        FULL,
        DISCARD
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pend_addr, pend_addr_n;

    logic        out_valid_n;
    logic [31:0] out_pc_n, out_instr_n;

    logic        buf_valid, buf_valid_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;

    logic        consume;

    assign out_pcplus4  = out_pc + 32'd4;
    assign out_pc_wdata = out_pcplus4;

    always_comb begin
        consume     = out_valid && !stall;

        state_n     = state;
        pc_n        = pc;
        pend_addr_n = pend_addr;
        out_valid_n = out_valid;
        out_pc_n    = out_pc;
        out_instr_n = out_instruction;
        buf_valid_n = buf_valid;
        buf_pc_n    = buf_pc;
        buf_instr_n = buf_instr;

        imem_rmask  = '0;
        imem_addr   = pc;
        case (state)
            REQ:     imem_rmask = '1;
            DISCARD: begin
                imem_rmask = '1;
                imem_addr  = pend_addr;
            end
            default: ;
        endcase
        if (rst) begin
            imem_rmask = '0;
        end

        if (redirect_valid) begin
            out_valid_n = 1'b0;
            buf_valid_n = 1'b0;
            pc_n        = {redirect_pc[31:2], 2'b00};
            // FULL has no read in flight. A response arriving in this very
            // cycle closes the in-flight read, so it is simply dropped.
            if (state == FULL || imem_resp) begin
                state_n = REQ;
            end else begin
                state_n = DISCARD;
                if (state == REQ) begin
                    pend_addr_n = pc;
                end
            end
        end else begin
            // Retire the consumed entry first, then refill out from the
            // older buf entry, and only then place a new response. This
            // keeps delivery in program order.
            if (consume) begin
                out_valid_n = 1'b0;
            end
            if (!out_valid_n && buf_valid) begin
                out_valid_n = 1'b1;
                out_pc_n    = buf_pc;
                out_instr_n = buf_instr;
                buf_valid_n = 1'b0;
            end
            if (state == REQ && imem_resp) begin
                pc_n = pc + 32'd4;
                if (!out_valid_n) begin
                    out_valid_n = 1'b1;
                    out_pc_n    = pc;
                    out_instr_n = imem_rdata;
                end else begin
                    buf_valid_n = 1'b1;
                    buf_pc_n    = pc;
                    buf_instr_n = imem_rdata;
                end
            end
            if (state == DISCARD) begin
                if (imem_resp) begin
                    state_n = REQ;
                end
            end else begin
                state_n = (out_valid_n && buf_valid_n) ? FULL : REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= REQ;
            pc              <= RESET_PC;
            pend_addr       <= '0;
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_instruction <= '0;
            buf_valid       <= 1'b0;
            buf_pc          <= '0;
            buf_instr       <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            pend_addr       <= pend_addr_n;
            out_valid       <= out_valid_n;
            out_pc          <= out_pc_n;
            out_instruction <= out_instr_n;
            buf_valid       <= buf_valid_n;
            buf_pc          <= buf_pc_n;
            buf_instr       <= buf_instr_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// The memory model answers a held request in its lat-th cycle; lat = 1 answers
// in the request cycle itself. Returned data is imem_addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_wdata;

    int          vectors     = 0;
    int          miscompares = 0;

    int unsigned lat  = 1;
    int unsigned mcnt = 0;

    fetch_stage #(
        .RESET_PC(32'h6000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_pcplus4    (out_pcplus4),
        .out_instruction(out_instruction),
        .out_pc_wdata   (out_pc_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: counts the cycles the current request has been held.
    always @(posedge clk) begin
        if (rst || imem_rmask != 4'hF || imem_resp) mcnt <= 0;
        else                                         mcnt <= mcnt + 1;
    end

    always_comb begin
        imem_resp  = (imem_rmask == 4'hF) && (mcnt + 1 >= lat);
        imem_rdata = imem_resp ? (imem_addr ^ 32'hA5A5_0000) : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b1;
        #0;
        chk("rmask_in_rst", {28'd0, imem_rmask}, 32'h0);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instruction, 32'h0);
        rst = 1'b0;
        #0;
        chk("post_rst_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("post_rst_addr", imem_addr, 32'h6000_0000);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = 1;
        tick();

        // Streaming with single-cycle memory
        do_reset();
        chk("c0_out_valid", {31'd0, out_valid}, 32'h0);
        tick();
        chk("c1_out_valid", {31'd0, out_valid}, 32'h1);
        chk("c1_out_pc", out_pc, 32'h6000_0000);
        chk("c1_out_instr", out_instruction, 32'hC5A5_0000);
        chk("c1_pcplus4", out_pcplus4, 32'h6000_0004);
        chk("c1_pc_wdata", out_pc_wdata, 32'h6000_0004);
        chk("c1_addr", imem_addr, 32'h6000_0004);
        tick();
        chk("c2_out_pc", out_pc, 32'h6000_0004);
        chk("c2_out_instr", out_instruction, 32'hC5A5_0004);
        chk("c2_addr", imem_addr, 32'h6000_0008);
        tick();
        chk("c3_out_pc", out_pc, 32'h6000_0008);
        chk("c3_addr", imem_addr, 32'h6000_000C);

        // Stall for 5 cycles after the first entry
        do_reset();
        tick();
        chk("s1_out_pc", out_pc, 32'h6000_0000);
        stall = 1'b1;
        tick();
        chk("s2_rmask_full", {28'd0, imem_rmask}, 32'h0);
        chk("s2_out_pc", out_pc, 32'h6000_0000);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("s_hold_rmask", {28'd0, imem_rmask}, 32'h0);
            chk("s_hold_out_pc", out_pc, 32'h6000_0000);
        end
        tick();
        stall = 1'b0;
        chk("s6_out_pc", out_pc, 32'h6000_0000);
        chk("s6_out_valid", {31'd0, out_valid}, 32'h1);
        tick();
        chk("s7_out_pc", out_pc, 32'h6000_0004);
        chk("s7_out_instr", out_instruction, 32'hC5A5_0004);
        chk("s7_addr", imem_addr, 32'h6000_0008);
        tick();
        chk("s8_out_pc", out_pc, 32'h6000_0008);
        chk("s8_out_valid", {31'd0, out_valid}, 32'h1);

        // Redirect with a 3-cycle read in flight
        lat = 3;
        do_reset();
        for (int unsigned i = 0; i < 6; i++) tick();
        chk("r6_out_pc", out_pc, 32'h6000_0004);
        chk("r6_addr", imem_addr, 32'h6000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("r7_out_valid", {31'd0, out_valid}, 32'h0);
        chk("r7_discard_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("r7_discard_addr", imem_addr, 32'h6000_0008);
        tick();
        tick();
        chk("r9_addr", imem_addr, 32'h6000_0100);
        chk("r9_out_valid", {31'd0, out_valid}, 32'h0);
        tick();
        tick();
        chk("r11_out_valid", {31'd0, out_valid}, 32'h0);
        tick();
        chk("r12_out_valid", {31'd0, out_valid}, 32'h1);
        chk("r12_out_pc", out_pc, 32'h6000_0100);
        chk("r12_out_instr", out_instruction, 32'hC5A5_0100);

        // Redirect while FULL, then redirect coinciding with a response
        lat   = 1;
        stall = 1'b1;
        tick();
        chk("f_rmask", {28'd0, imem_rmask}, 32'h0);
        chk("f_out_pc", out_pc, 32'h6000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("f_flush_valid", {31'd0, out_valid}, 32'h0);
        chk("f_flush_addr", imem_addr, 32'h6000_0200);
        tick();
        chk("f_new_out_pc", out_pc, 32'h6000_0200);
        chk("f_resp_pending", {31'd0, imem_resp}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("rr_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rr_rmask", {28'd0, imem_rmask}, 32'hF);
        chk("rr_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap
        tick();
        chk("w_out_pc", out_pc, 32'hFFFF_FFFC);
        chk("w_pcplus4", out_pcplus4, 32'h0000_0000);
        chk("w_pc_wdata", out_pc_wdata, 32'h0000_0000);
        chk("w_out_instr", out_instruction, 32'h5A5A_FFFC);
        chk("w_addr", imem_addr, 32'h0000_0000);
        tick();
        chk("w2_out_pc", out_pc, 32'h0000_0000);
        chk("w2_out_instr", out_instruction, 32'hA5A5_0000);
        chk("w2_pcplus4", out_pcplus4, 32'h0000_0004);

        // Reset while FULL
        stall = 1'b1;
        tick();
        chk("rf_rmask_full", {28'd0, imem_rmask}, 32'h0);
        do_reset();
        stall = 1'b0;
        tick();
        chk("rf_out_pc", out_pc, 32'h6000_0000);
        chk("rf_out_instr", out_instruction, 32'hC5A5_0000);

        // Reset while DISCARD
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6000_0300;
        tick();
        redirect_valid = 1'b0;
        chk("rd_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rd_discard_addr", imem_addr, 32'h6000_0004);
        do_reset();
        tick();
        chk("rd1_out_valid", {31'd0, out_valid}, 32'h0);
        tick();
        chk("rd2_out_valid", {31'd0, out_valid}, 32'h0);
        tick();
        chk("rd3_out_valid", {31'd0, out_valid}, 32'h1);
        chk("rd3_out_pc", out_pc, 32'h6000_0000);
        chk("rd3_out_instr", out_instruction, 32'hC5A5_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
